// File: rtl/data_memory_param_if.sv
// Request/response bundle for data_memory_param: byte-masked write port,
// registered read port and status flags.
interface data_memory_param_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 8
);
  logic                      mem_signal_write;
  logic [DATA_WIDTH/8-1:0]   mem_byte_en;
  logic [ADDR_WIDTH-1:0]     mem_addr_write;
  logic [DATA_WIDTH-1:0]     mem_data_write;
  logic                      mem_read_en;
  logic [ADDR_WIDTH-1:0]     mem_addr_read;
  logic [DATA_WIDTH-1:0]     mem_data_read;
  logic                      mem_read_valid;
  logic                      data_retained;
  logic                      mem_ready;

  modport master (
    output mem_signal_write, mem_byte_en, mem_addr_write, mem_data_write,
           mem_read_en, mem_addr_read,
    input  mem_data_read, mem_read_valid, data_retained, mem_ready
  );

  modport slave (
    input  mem_signal_write, mem_byte_en, mem_addr_write, mem_data_write,
           mem_read_en, mem_addr_read,
    output mem_data_read, mem_read_valid, data_retained, mem_ready
  );
endinterface

// File: rtl/data_memory_param.sv
// Byte-maskable single-clock data memory that zero-fills itself after reset
// and then serves write-first, one-cycle-latency reads.
module data_memory_param #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  data_memory_param_if.slave   bus
);

  localparam int unsigned NBYTES = DATA_WIDTH / 8;
  localparam int unsigned DEPTH  = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH+1)'(DEPTH - 1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH:0]   clr_cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  wr_commit;
  logic                  rd_accept;
  logic [DATA_WIDTH-1:0] wr_word;
  logic [DATA_WIDTH-1:0] rd_word;

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == CLEAR)
        clr_cnt <= clr_cnt + 1'b1;
    end
  end

  // Merged write word is also the bypass value for a same-address read.
  always_comb begin
    state_next = state;
    wr_commit  = 1'b0;
    rd_accept  = 1'b0;
    wr_word    = mem[bus.mem_addr_write];
    rd_word    = mem[bus.mem_addr_read];
    for (int unsigned i = 0; i < NBYTES; i++) begin
      if (bus.mem_byte_en[i])
        wr_word[8*i +: 8] = bus.mem_data_write[8*i +: 8];
    end
    case (state)
      CLEAR: begin
        if (clr_cnt == LAST_ADDR)
          state_next = READY;
      end
      READY: begin
        wr_commit = bus.mem_signal_write && (bus.mem_byte_en != '0);
        rd_accept = bus.mem_read_en;
        if (wr_commit && (bus.mem_addr_write == bus.mem_addr_read))
          rd_word = wr_word;
      end
      default: state_next = CLEAR;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state == CLEAR)
        mem[clr_cnt[ADDR_WIDTH-1:0]] <= '0;
      else if (wr_commit)
        mem[bus.mem_addr_write] <= wr_word;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bus.mem_data_read  <= '0;
      bus.mem_read_valid <= 1'b0;
      bus.data_retained  <= 1'b1;
      bus.mem_ready      <= 1'b0;
    end else begin
      bus.mem_read_valid <= rd_accept;
      bus.data_retained  <= !wr_commit;
      bus.mem_ready      <= (state_next == READY);
      if (rd_accept)
        bus.mem_data_read <= rd_word;
    end
  end

endmodule

// File: doc/data_memory_param.md
DATA_MEMORY_PARAM -- requirements
Module: data_memory_param

Interface
REQ-001 Parameter DATA_WIDTH, default 16, word width in bits; SHALL be a multiple of 8 and at least 8.
REQ-002 Parameter ADDR_WIDTH, default 8, address width; depth SHALL be DEPTH = 2**ADDR_WIDTH words.
REQ-003 Port clock  input  1  processor clock; all state SHALL change on its rising edge only.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port mem_signal_write  input  1  write request.
REQ-006 Port mem_byte_en  input  DATA_WIDTH/8  per-byte write enable; bit i covers data bits [8i+7:8i].
REQ-007 Port mem_addr_write  input  ADDR_WIDTH  write address.
REQ-008 Port mem_data_write  input  DATA_WIDTH  write data.
REQ-009 Port mem_read_en  input  1  read request.
REQ-010 Port mem_addr_read  input  ADDR_WIDTH  read address.
REQ-011 Port mem_data_read  output  DATA_WIDTH  registered read data.
REQ-012 Port mem_read_valid  output  1  mem_data_read holds the result of a read accepted on the previous edge.
REQ-013 Port data_retained  output  1  registered; 1 = no word changed on the last edge, 0 = a write committed.
REQ-014 Port mem_ready  output  1  high when the clear sequence is done and requests are accepted.

Function
REQ-015 The block SHALL implement a two-state FSM: CLEAR and READY.
REQ-016 In CLEAR, each edge SHALL write zero to memory[clr_cnt] and increment clr_cnt (ADDR_WIDTH+1 bits); on the edge that clears address DEPTH-1, the state SHALL become READY.
REQ-017 In CLEAR, mem_ready SHALL be 0, and write and read requests SHALL be ignored: memory is untouched except by the clear, mem_read_valid=0, data_retained=1.
REQ-018 In READY, mem_ready SHALL be 1, and READY SHALL persist until reset.
REQ-019 A write SHALL commit when state=READY, mem_signal_write=1 and mem_byte_en is nonzero; only enabled byte lanes are updated, and other lanes keep their old value.
REQ-020 A write with mem_byte_en all zero SHALL be treated as no write, with data_retained=1.
REQ-021 data_retained SHALL be 0 on the edge after a committed write and 1 otherwise.
REQ-022 A read SHALL be accepted when state=READY and mem_read_en=1; mem_data_read and mem_read_valid=1 SHALL appear after the next edge (1-cycle latency).
REQ-023 When no read is accepted, mem_read_valid SHALL be 0 and mem_data_read SHALL hold its previous value.
REQ-024 Simultaneous read and write to the same address SHALL be write-first: returned data = old word with enabled lanes replaced by mem_data_write.
REQ-025 Simultaneous read and write to different addresses SHALL be independent.
REQ-026 Back-to-back reads on consecutive cycles SHALL each return data with no bubble (one result per cycle).

Reset
REQ-027 While reset=1 on an edge: state<=CLEAR, clr_cnt<=0, mem_data_read<=0, mem_read_valid<=0, data_retained<=1, mem_ready<=0.
REQ-028 The first edge with reset=0 SHALL clear address 0, and mem_ready SHALL rise after exactly DEPTH edges with reset=0 (256 for defaults).
REQ-029 Reset asserted mid-CLEAR or in READY SHALL restart the sequence from address 0; partially written data SHALL be zeroed again.
REQ-030 Memory contents SHALL NOT depend on simulator initial values once mem_ready=1.

Verification
REQ-031 Reset 1 cycle, release, then count edges -> mem_ready=1 after exactly 256 edges; read of addr 0xFF returns 0x0000 with valid=1.
REQ-032 Write 0xBEEF to 0x10 with byte_en=2'b11, then read 0x10 -> next-cycle data 0xBEEF, valid=1; data_retained=0 the edge after the write, 1 after that.
REQ-033 With 0x10=0xBEEF, write 0x1234 with byte_en=2'b01, then read -> 0xBE34; write with byte_en=2'b00 -> data_retained=1 and 0x10 unchanged.
REQ-034 Same cycle: write 0xA5A5 to 0x20 (byte_en=2'b10) and read 0x20, where 0x20=0x0000 -> returned 0xA500.
REQ-035 Write 0x5555 to 0x30, then assert reset at clear count 100 -> mem_ready stays 0 for 256 more edges; read 0x30 then returns 0x0000.
REQ-036 Writes and reads during CLEAR (before mem_ready) -> mem_read_valid=0, data_retained=1, and no written value is visible after ready.
